// File: rtl/txt_console.sv
// Character-cell console: interprets a CPU byte stream, keeps a cursor and fills a
// COLS x ROWS glyph RAM that the text-mode sequencer reads through a separate port.
module txt_console #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              disp_mem_en,
    input  logic [ADDR_W-1:0] ascii_address,
    output logic [7:0]        char_code,
    output logic [5:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = $clog2(CELLS);

    localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] SCR_LAST_A = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] WRAP_A     = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
    localparam logic [5:0]        X_MAX      = 6'(COLS - 1);
    localparam logic [4:0]        Y_MAX      = 5'(ROWS - 1);

    typedef enum logic [2:0] {CLEAR, IDLE, SCR_RD, SCR_WR, BLANK} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] scr_raddr;
    logic [7:0]        scr_data;
    logic              accept, printable, at_bottom, disp_in_range;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;

    logic [7:0] ram [0:CELLS-1];

    assign accept        = char_valid && char_ready;
    assign printable     = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign at_bottom     = (cursor_y == Y_MAX);
    assign scr_raddr     = ptr + COLS_A;
    assign disp_in_range = (ascii_address <= LAST_A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CLEAR;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:  if (ptr == LAST_A) state_nxt = IDLE;
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        if (cursor_x == X_MAX && at_bottom) state_nxt = SCR_RD;
                    end else if (char_in == 8'h0A) begin
                        if (at_bottom) state_nxt = SCR_RD;
                    end else if (char_in == 8'h0C) begin
                        state_nxt = CLEAR;
                    end
                end
            end
            SCR_RD: state_nxt = SCR_WR;
            SCR_WR: state_nxt = (ptr == SCR_LAST_A) ? BLANK : SCR_RD;
            BLANK:  if (ptr == LAST_A) state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        char_ready = (state == IDLE);
        busy       = (state != IDLE);
        we         = 1'b0;
        waddr      = ptr;
        wdata      = CLEAR_CHAR;
        case (state)
            CLEAR, BLANK: we = 1'b1;
            SCR_WR: begin
                we    = 1'b1;
                wdata = scr_data;
            end
            IDLE: begin
                we    = accept && printable;
                waddr = cur_addr;
                wdata = char_in;
            end
            default: ;
        endcase
    end

    // Sweep pointer for clear/scroll/blank and the incrementally maintained cursor address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            cur_addr <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ptr <= '0;
                    if (accept) begin
                        if (printable) begin
                            if (cursor_x != X_MAX) begin
                                cursor_x <= cursor_x + 6'd1;
                                cur_addr <= cur_addr + ONE_A;
                            end else begin
                                cursor_x <= '0;
                                if (!at_bottom) begin
                                    cursor_y <= cursor_y + 5'd1;
                                    cur_addr <= cur_addr + ONE_A;
                                end else begin
                                    cur_addr <= cur_addr - WRAP_A;
                                end
                            end
                        end else begin
                            case (char_in)
                                8'h0D: begin
                                    cursor_x <= '0;
                                    cur_addr <= cur_addr - ADDR_W'(cursor_x);
                                end
                                8'h0A: if (!at_bottom) begin
                                    cursor_y <= cursor_y + 5'd1;
                                    cur_addr <= cur_addr + COLS_A;
                                end
                                8'h08: begin
                                    if (cursor_x != 6'd0) begin
                                        cursor_x <= cursor_x - 6'd1;
                                        cur_addr <= cur_addr - ONE_A;
                                    end else if (cursor_y != 5'd0) begin
                                        cursor_x <= X_MAX;
                                        cursor_y <= cursor_y - 5'd1;
                                        cur_addr <= cur_addr - ONE_A;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLEAR: begin
                    ptr <= (ptr == LAST_A) ? '0 : ptr + ONE_A;
                    if (ptr == LAST_A) begin
                        cursor_x <= '0;
                        cursor_y <= '0;
                        cur_addr <= '0;
                    end
                end
                SCR_WR, BLANK: ptr <= (state_nxt == IDLE) ? '0 : ptr + ONE_A;
                default: ;
            endcase
        end
    end

    // NOTE: the glyph RAM has no reset; CLEAR after reset defines every cell.
    always_ff @(posedge clk) begin
        if (we) ram[waddr[IDX_W-1:0]] <= wdata;
        if (state == SCR_RD) scr_data <= ram[scr_raddr[IDX_W-1:0]];
    end

    // NOTE: non-blocking reads against the same-edge write give read-first behaviour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            char_code <= 8'h00;
        else if (disp_mem_en)
            char_code <= disp_in_range ? ram[ascii_address[IDX_W-1:0]] : 8'h00;
    end

endmodule

// File: tb/tb_txt_console.sv
// Self-checking bench for txt_console: a behavioural screen model feeds a scoreboard
// queue of expected display reads that are popped as char_code appears.
module tb_txt_console;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        disp_mem_en;
    logic [11:0] ascii_address;
    logic [7:0]  char_code;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl_mem [CELLS];
    int mx, my;

    txt_console dut (
        .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .disp_mem_en(disp_mem_en), .ascii_address(ascii_address),
        .char_code(char_code), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void mdl_clear();
        for (int i = 0; i < CELLS; i++) mdl_mem[i] = 8'h20;
        mx = 0;
        my = 0;
    endfunction

    function automatic void mdl_lf();
        if (my < ROWS - 1) my++;
        else begin
            for (int i = 0; i < (ROWS - 1) * COLS; i++) mdl_mem[i] = mdl_mem[i + COLS];
            for (int i = (ROWS - 1) * COLS; i < CELLS; i++) mdl_mem[i] = 8'h20;
        end
    endfunction

    function automatic void mdl_put(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            mdl_mem[my * COLS + mx] = b;
            if (mx < COLS - 1) mx++;
            else begin
                mx = 0;
                mdl_lf();
            end
        end else if (b == 8'h0D) mx = 0;
        else if (b == 8'h0A) mdl_lf();
        else if (b == 8'h08) begin
            if (mx > 0) mx--;
            else if (my > 0) begin
                mx = COLS - 1;
                my--;
            end
        end else if (b == 8'h0C) mdl_clear();
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, output int waits);
        char_in    = b;
        char_valid = 1'b1;
        waits      = 0;
        while (!char_ready && waits < LIMIT) begin
            waits++;
            @(negedge clk);
        end
        n_checks++;
        if (!char_ready) begin
            n_fail++;
            $display("FAIL send_byte %h: char_ready=%b after %0d cycles, required 1", b, char_ready, waits);
        end
        @(negedge clk);
        char_valid = 1'b0;
        mdl_put(b);
    endtask

    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 0;
        while (busy && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (busy || n != exp_cycles) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d (busy=%b), required %0d", tag, n, busy, exp_cycles);
        end
    endtask

    task automatic read_screen(input string tag);
        logic [7:0] exp_q [$];
        logic [7:0] exp;
        for (int a = 0; a < CELLS + 2; a++) begin
            disp_mem_en   = 1'b1;
            ascii_address = (a < CELLS) ? 12'(a) : ((a == CELLS) ? 12'(CELLS) : 12'hFFF);
            exp_q.push_back((a < CELLS) ? mdl_mem[a] : 8'h00);
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (char_code !== exp) begin
                n_fail++;
                $display("FAIL %s cell %0d: char_code=%h, required %h", tag, a, char_code, exp);
            end
        end
        disp_mem_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || char_code !== 8'h00 ||
            char_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: x=%0d y=%0d code=%h ready=%b busy=%b, required 0 0 00 0 1",
                     cursor_x, cursor_y, char_code, char_ready, busy);
        end
        reset = 1'b1;
        wait_idle("reset_clear", 1200);
        mdl_clear();
        read_screen("reset_screen");
        disp_mem_en   = 1'b1;
        ascii_address = 12'd5;
        @(negedge clk);
        disp_mem_en   = 1'b0;
        ascii_address = 12'd1200;
        repeat (3) @(negedge clk);
        n_checks++;
        if (char_code !== 8'h20) begin
            n_fail++;
            $display("FAIL display_hold: char_code=%h, required 20", char_code);
        end
    endtask

    task automatic test_print();
        logic [7:0] seq [4] = '{8'h41, 8'h42, 8'h0D, 8'h43};
        int w;
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], w);
            n_checks++;
            if (w != 0) begin
                n_fail++;
                $display("FAIL print_ready byte %0d: waited %0d cycles, required 0", i, w);
            end
        end
        n_checks++;
        if (cursor_x !== 6'd1 || cursor_y !== 5'd0) begin
            n_fail++;
            $display("FAIL print_cursor: (%0d,%0d), required (1,0)", cursor_x, cursor_y);
        end
        read_screen("print_screen");
    endtask

    task automatic test_wrap_scroll();
        int w;
        for (int i = 0; i < 38; i++) send_byte(8'h61 + 8'(i % 26), w);
        n_checks++;
        if (cursor_x !== 6'd39 || cursor_y !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_pre: (%0d,%0d), required (39,0)", cursor_x, cursor_y);
        end
        send_byte(8'h5A, w);
        n_checks++;
        if (cursor_x !== 6'd0 || cursor_y !== 5'd1) begin
            n_fail++;
            $display("FAIL wrap_cursor: (%0d,%0d), required (0,1)", cursor_x, cursor_y);
        end
        for (int i = 0; i < 28; i++) send_byte(8'h0A, w);
        for (int i = 0; i < 39; i++) send_byte(8'h30 + 8'(i % 10), w);
        n_checks++;
        if (cursor_x !== 6'd39 || cursor_y !== 5'd29) begin
            n_fail++;
            $display("FAIL scroll_pre: (%0d,%0d), required (39,29)", cursor_x, cursor_y);
        end
        send_byte(8'h51, w);
        wait_idle("scroll", 2360);
        n_checks++;
        if (cursor_x !== 6'd0 || cursor_y !== 5'd29) begin
            n_fail++;
            $display("FAIL scroll_cursor: (%0d,%0d), required (0,29)", cursor_x, cursor_y);
        end
        disp_mem_en   = 1'b1;
        ascii_address = 12'(28 * COLS + 39);
        @(negedge clk);
        disp_mem_en = 1'b0;
        n_checks++;
        if (char_code !== 8'h51) begin
            n_fail++;
            $display("FAIL scroll_q_cell: char_code=%h, required 51", char_code);
        end
        read_screen("scroll_screen");
    endtask

    task automatic test_form_feed();
        int w, n;
        send_byte(8'h4D, w);
        send_byte(8'h4E, w);
        send_byte(8'h0C, w);
        char_in    = 8'h58;
        char_valid = 1'b1;
        n = 0;
        while (!char_ready && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 1200) begin
            n_fail++;
            $display("FAIL ff_hold_valid: ready after %0d cycles, required 1200", n);
        end
        @(negedge clk);
        char_valid = 1'b0;
        mdl_put(8'h58);
        n_checks++;
        if (cursor_x !== 6'd1 || cursor_y !== 5'd0) begin
            n_fail++;
            $display("FAIL ff_cursor: (%0d,%0d), required (1,0)", cursor_x, cursor_y);
        end
        read_screen("ff_screen");
    endtask

    task automatic test_backspace();
        int w;
        send_byte(8'h0D, w);
        for (int i = 0; i < 5; i++) send_byte(8'h0A, w);
        send_byte(8'h08, w);
        n_checks++;
        if (cursor_x !== 6'd39 || cursor_y !== 5'd4) begin
            n_fail++;
            $display("FAIL bs_row_wrap: (%0d,%0d), required (39,4)", cursor_x, cursor_y);
        end
        for (int i = 0; i < 199; i++) send_byte(8'h08, w);
        n_checks++;
        if (cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
            n_fail++;
            $display("FAIL bs_to_home: (%0d,%0d), required (0,0)", cursor_x, cursor_y);
        end
        send_byte(8'h08, w);
        send_byte(8'h07, w);
        n_checks++;
        if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || w != 0) begin
            n_fail++;
            $display("FAIL bs_home_bel: (%0d,%0d) waits=%0d, required (0,0) 0", cursor_x, cursor_y, w);
        end
        read_screen("bs_screen");
    endtask

    task automatic test_reset_mid_scroll();
        int w;
        for (int i = 0; i < 29; i++) send_byte(8'h0A, w);
        for (int i = 0; i < 5; i++) send_byte(8'h4B, w);
        disp_mem_en   = 1'b1;
        ascii_address = 12'(29 * COLS);
        @(negedge clk);
        disp_mem_en = 1'b0;
        n_checks++;
        if (char_code !== 8'h4B || cursor_x !== 6'd5 || cursor_y !== 5'd29) begin
            n_fail++;
            $display("FAIL abort_pre: code=%h (%0d,%0d), required 4b (5,29)", char_code, cursor_x, cursor_y);
        end
        send_byte(8'h0A, w);
        repeat (499) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy: busy=%b, required 1", busy);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || char_code !== 8'h00 ||
            char_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reset: x=%0d y=%0d code=%h ready=%b busy=%b, required 0 0 00 0 1",
                     cursor_x, cursor_y, char_code, char_ready, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_idle("abort_clear", 1200);
        mdl_clear();
        read_screen("abort_screen");
    endtask

    initial begin
        reset         = 1'b0;
        char_in       = 8'h00;
        char_valid    = 1'b0;
        disp_mem_en   = 1'b0;
        ascii_address = '0;
        test_reset();
        test_print();
        test_wrap_scroll();
        test_form_feed();
        test_backspace();
        test_reset_mid_scroll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
